// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, I-cache frame and I-cache FSM state.
// Frame tags are stored at the widest width any legal SETS value can need.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS    = 16;
    localparam int ICACHE_IDX_W   = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W   = 30 - ICACHE_IDX_W;
    // SETS >= 2 leaves at most 29 tag bits; narrower tags are zero-padded
    localparam int ICACHE_TAG_MAX = 29;

    typedef logic [ICACHE_TAG_MAX-1:0] icache_tag_t;

    typedef struct packed {
        logic        valid;
        icache_tag_t tag;
        word_t       data;
    } icache_frame_t;

    typedef enum logic {
        IDLE,
        FETCH
    } icache_state_t;

    function automatic icache_tag_t icache_tag(word_t addr, int idx_w);
        word_t sh;
        sh = addr >> (idx_w + 2);
        return sh[ICACHE_TAG_MAX-1:0];
    endfunction

endpackage

// File: rtl/icache_responder.sv
// Direct-mapped one-word-block instruction cache with blocking miss fill.
// Optional ICACHE_BYPASS_EN forwards fill data to the datapath in the fill cycle.
module icache_responder
    import cpu_types_pkg::*;
#(
    parameter int    SETS    = ICACHE_SETS,
    parameter word_t PC_INIT = '0
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output word_t imemload,
    output logic  ihit,
    output logic  iREN,
    output word_t iaddr,
    input  word_t iload,
    input  logic  iwait
);

    localparam int IDX = $clog2(SETS);

    icache_state_t state_q, state_d;
    word_t         miss_q, miss_d;
    icache_frame_t frames_q [SETS];

    logic [IDX-1:0] req_idx;
    logic [IDX-1:0] miss_idx;
    icache_frame_t  sel;
    logic           hit;
    logic           fill;

    assign req_idx  = imemaddr[IDX+1:2];
    assign miss_idx = miss_q[IDX+1:2];
    assign sel      = frames_q[req_idx];
    assign hit      = imemREN & sel.valid
                    & (sel.tag == icache_tag(imemaddr, IDX));

    // FSM state and latched miss address
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            miss_q  <= PC_INIT;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
        end
    end

    // Frame array: cleared on reset, written once per completed fill
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) begin
                frames_q[i] <= '0;
            end
        end else if (fill) begin
            frames_q[miss_idx] <= '{
                valid: 1'b1,
                tag:   icache_tag(miss_q, IDX),
                data:  iload
            };
        end
    end

    // Next state, hit response and memory request
    always_comb begin
        state_d  = state_q;
        miss_d   = miss_q;
        ihit     = 1'b0;
        imemload = '0;
        iREN     = 1'b0;
        iaddr    = '0;
        fill     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    ihit     = 1'b1;
                    imemload = sel.data;
                end else if (imemREN) begin
                    miss_d  = imemaddr;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {miss_q[31:2], 2'b00};
                if (!iwait) begin
                    fill    = 1'b1;
                    state_d = IDLE;
`ifdef ICACHE_BYPASS_EN
                    if (imemREN && (imemaddr[31:2] == miss_q[31:2])) begin
                        ihit     = 1'b1;
                        imemload = iload;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
